// File: rtl/ifid_hazard_stage.sv
// IF stage: PC register, IF/ID pipeline register, load-use stall
// detection and EX-resolved redirect flush with perf counters.
module ifid_hazard_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr_in,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rt,
   input  logic             redirect,
   input  logic [31:0]      redirect_target,
   output logic [31:0]      pc_out,
   output logic [31:0]      ifid_instr,
   output logic [31:0]      ifid_pc,
   output logic             ifid_valid,
   output logic             stall,
   output logic             ctrl_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
   } if_id_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   if_id_t           ifid_q;
   logic [31:0]      pc_q;
   logic [31:0]      pc_plus4;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;
   logic             hit_rs;
   logic             hit_rt;
   logic             hazard;

   assign pc_plus4 = pc_q + 32'd4;

   // Load-use hazard: rs/rt of the decoding instr vs. load dest in EX.
   // rt is compared for every opcode; a redirect kills the stall.
   always_comb begin
      hit_rs = (idex_rt == ifid_q.instr[25:21]);
      hit_rt = (idex_rt == ifid_q.instr[20:16]);
      hazard = ifid_q.valid & idex_memread
             & (idex_rt != 5'd0) & (hit_rs | hit_rt);
      stall       = hazard & ~redirect;
      ctrl_bubble = stall | redirect;
   end

   // PC, IF/ID and counters: rst > redirect > stall > normal.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         ifid_q.instr <= 32'd0;
         ifid_q.pc    <= 32'd0;
         ifid_q.valid <= 1'b0;
         stall_q      <= '0;
         flush_q      <= '0;
      end else begin
         unique case (1'b1)
            redirect: begin
               pc_q         <= redirect_target;
               ifid_q.instr <= 32'd0;
               ifid_q.pc    <= 32'd0;
               ifid_q.valid <= 1'b0;
               if (flush_q != CNT_MAX)
                  flush_q <= flush_q + CNT_ONE;
            end
            stall: begin
               if (stall_q != CNT_MAX)
                  stall_q <= stall_q + CNT_ONE;
            end
            default: begin
               pc_q         <= pc_plus4;
               ifid_q.instr <= instr_in;
               ifid_q.pc    <= pc_plus4;
               ifid_q.valid <= 1'b1;
            end
         endcase
      end
   end

   assign pc_out     = pc_q;
   assign ifid_instr = ifid_q.instr;
   assign ifid_pc    = ifid_q.pc;
   assign ifid_valid = ifid_q.valid;
   assign stall_cnt  = stall_q;
   assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_ifid_hazard_stage.sv
// Directed bench for ifid_hazard_stage with a reference model and
// an expected-state queue popped after each clock edge.
module tb_ifid_hazard_stage;

   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   instr_in;
   logic          idex_memread;
   logic [4:0]    idex_rt;
   logic          redirect;
   logic [31:0]   redirect_target;
   logic [31:0]   pc_out;
   logic [31:0]   ifid_instr;
   logic [31:0]   ifid_pc;
   logic          ifid_valid;
   logic          stall;
   logic          ctrl_bubble;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;

   always #5 clk = ~clk;

   ifid_hazard_stage #(
      .RESET_PC (32'h0000_0000),
      .CNT_W    (CW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .instr_in        (instr_in),
      .idex_memread    (idex_memread),
      .idex_rt         (idex_rt),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .pc_out          (pc_out),
      .ifid_instr      (ifid_instr),
      .ifid_pc         (ifid_pc),
      .ifid_valid      (ifid_valid),
      .stall           (stall),
      .ctrl_bubble     (ctrl_bubble),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   typedef struct packed {
      logic [31:0]   pc;
      logic [31:0]   instr;
      logic [31:0]   ipc;
      logic          valid;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } snap_t;

   snap_t q[$];

   int checks   = 0;
   int failures = 0;

   logic          m_known = 1'b0;
   logic [31:0]   m_pc;
   logic [31:0]   m_instr;
   logic [31:0]   m_ipc;
   logic          m_valid;
   logic [CW-1:0] m_sc;
   logic [CW-1:0] m_fc;

   localparam logic [31:0] ADD_R1 = 32'h0022_1820;
   localparam logic [31:0] ADD_R0 = 32'h0000_1820;
   localparam logic [31:0] NOPI   = 32'h0000_0020;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic [31:0] ins,
                        input logic mr, input logic [4:0] rt,
                        input logic rd, input logic [31:0] tgt);
      snap_t e;
      logic  es;
      rst             = r;
      instr_in        = ins;
      idex_memread    = mr;
      idex_rt         = rt;
      redirect        = rd;
      redirect_target = tgt;
      #1;
      es = m_valid & mr & (rt != 5'd0) & ~rd
         & ((rt == m_instr[25:21]) | (rt == m_instr[20:16]));
      if (m_known) begin
         chk("stall", 32'(stall), 32'(es));
         chk("ctrl_bubble", 32'(ctrl_bubble), 32'(es | rd));
      end
      if (r) begin
         m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
         m_valid = 1'b0; m_sc = '0; m_fc = '0;
         m_known = 1'b1;
      end else if (rd) begin
         m_pc = tgt; m_instr = 32'h0; m_ipc = 32'h0; m_valid = 1'b0;
         if (m_fc != '1) m_fc = m_fc + CW'(1);
      end else if (es) begin
         if (m_sc != '1) m_sc = m_sc + CW'(1);
      end else begin
         m_instr = ins; m_ipc = m_pc + 32'd4; m_valid = 1'b1;
         m_pc = m_pc + 32'd4;
      end
      q.push_back('{m_pc, m_instr, m_ipc, m_valid, m_sc, m_fc});
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk("pc_out", pc_out, e.pc);
      chk("ifid_instr", ifid_instr, e.instr);
      chk("ifid_pc", ifid_pc, e.ipc);
      chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
      chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
      chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
      @(negedge clk);
   endtask

   task automatic run(input logic [31:0] ins);
      cycle(1'b0, ins, 1'b0, 5'd0, 1'b0, 32'h0);
   endtask

   initial begin
      @(negedge clk);
      cycle(1'b1, NOPI, 1'b0, 5'd0, 1'b0, 32'h0);
      cycle(1'b1, NOPI, 1'b0, 5'd0, 1'b0, 32'h0);
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_valid", 32'(ifid_valid), 32'h0);
      chk("rst_instr", ifid_instr, 32'h0);

      run(NOPI);
      chk("run_pc1", pc_out, 32'h4);
      chk("run_ipc1", ifid_pc, 32'h4);
      chk("run_valid", 32'(ifid_valid), 32'h1);
      run(NOPI);
      chk("run_pc2", pc_out, 32'h8);
      run(NOPI);
      chk("run_pc3", pc_out, 32'hC);
      chk("run_ipc3", ifid_pc, 32'hC);

      run(ADD_R1);
      cycle(1'b0, NOPI, 1'b1, 5'd1, 1'b0, 32'h0);
      chk("lu_cnt", 32'(stall_cnt), 32'h1);
      chk("lu_hold_pc", pc_out, 32'h10);
      chk("lu_hold_instr", ifid_instr, ADD_R1);
      cycle(1'b0, NOPI, 1'b0, 5'd1, 1'b0, 32'h0);
      chk("lu_clear_pc", pc_out, 32'h14);

      run(ADD_R0);
      cycle(1'b0, NOPI, 1'b1, 5'd0, 1'b0, 32'h0);
      chk("rt0_nostall_cnt", 32'(stall_cnt), 32'h1);
      run(ADD_R1);
      cycle(1'b0, NOPI, 1'b1, 5'd5, 1'b0, 32'h0);
      chk("rt5_nostall_cnt", 32'(stall_cnt), 32'h1);
      run(ADD_R1);
      cycle(1'b0, NOPI, 1'b1, 5'd2, 1'b0, 32'h0);
      chk("rtfield_stall_cnt", 32'(stall_cnt), 32'h2);

      cycle(1'b0, NOPI, 1'b0, 5'd0, 1'b1, 32'h0000_0100);
      chk("rd_pc", pc_out, 32'h100);
      chk("rd_valid", 32'(ifid_valid), 32'h0);
      chk("rd_cnt", 32'(flush_cnt), 32'h1);
      cycle(1'b0, NOPI, 1'b1, 5'd1, 1'b0, 32'h0);
      chk("bubble_nostall_pc", pc_out, 32'h104);

      run(ADD_R1);
      cycle(1'b0, NOPI, 1'b1, 5'd1, 1'b1, 32'h0000_0200);
      chk("both_pc", pc_out, 32'h200);
      chk("both_scnt", 32'(stall_cnt), 32'h2);
      chk("both_fcnt", 32'(flush_cnt), 32'h2);

      run(ADD_R1);
      for (int i = 0; i < 5; i++)
         cycle(1'b0, NOPI, 1'b1, 5'd1, 1'b0, 32'h0);
      chk("sat_scnt", 32'(stall_cnt), 32'h3);

      cycle(1'b0, NOPI, 1'b0, 5'd0, 1'b1, 32'hFFFF_FFFC);
      chk("fcnt3", 32'(flush_cnt), 32'h3);
      run(NOPI);
      chk("wrap_pc", pc_out, 32'h0);
      chk("wrap_ipc", ifid_pc, 32'h0);
      cycle(1'b0, NOPI, 1'b0, 5'd0, 1'b1, 32'h0000_0033);
      chk("sat_fcnt", 32'(flush_cnt), 32'h3);
      chk("unaligned_pc", pc_out, 32'h33);

      run(ADD_R1);
      cycle(1'b1, NOPI, 1'b1, 5'd1, 1'b0, 32'h0);
      chk("rst_stall_pc", pc_out, 32'h0);
      chk("rst_stall_scnt", 32'(stall_cnt), 32'h0);
      chk("rst_stall_fcnt", 32'(flush_cnt), 32'h0);
      chk("rst_stall_valid", 32'(ifid_valid), 32'h0);
      run(ADD_R1);
      cycle(1'b1, NOPI, 1'b0, 5'd0, 1'b1, 32'h0000_0400);
      chk("rst_rd_pc", pc_out, 32'h0);
      chk("rst_rd_instr", ifid_instr, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
